// File: rtl/hamming_fifo_reader.sv
// hamming_fifo_reader
//   Read-side consumer of the ECC buffer FIFO. Pops SECDED Hamming codewords
//   with the ffbrreq/ffbempty/ffbdo handshake, corrects single-bit errors,
//   flags double-bit (and invalid-position) errors, and delivers the words in
//   order on a valid/ready stream. Keeps saturating error counters.
//
//   Codeword layout: cw[0] is overall parity, cw[p] (p >= 1) is Hamming
//   position p. Power-of-two positions hold parity. Data bits fill the
//   remaining positions in ascending order, data LSB first.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ffbempty, ffbrreq     FIFO empty flag / pop request
//   ffbdo [CW]            FIFO data, valid the cycle after an accepted pop
//   dout_valid/ready      output stream handshake
//   dout [DW]             corrected data (raw extracted data when dout_ue)
//   dout_ce, dout_ue      corrected / uncorrectable flags
//   dout_syn [PW-1]       Hamming syndrome of the word
//   err_clr               clears both counters (wins over increment)
//   ce_cnt, ue_cnt [ECW]  saturating error counters
module hamming_fifo_reader #(
  parameter int DW  = 32,
  parameter int PW  = 7,
  parameter int OD  = 2,
  parameter int ECW = 16,
  localparam int CW = DW + PW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ffbempty,
  output logic           ffbrreq,
  input  logic [CW-1:0]  ffbdo,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [DW-1:0]  dout,
  output logic           dout_ce,
  output logic           dout_ue,
  output logic [PW-2:0]  dout_syn,
  input  logic           err_clr,
  output logic [ECW-1:0] ce_cnt,
  output logic [ECW-1:0] ue_cnt
);

  localparam int SW = PW - 1;
  localparam int AW = (OD > 1) ? $clog2(OD) : 1;
  localparam int NW = $clog2(OD + 1);
  localparam int UW = NW + 1;

  // Codeword position of data bit i: the i-th non-power-of-two position.
  function automatic int data_pos(input int i);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == i) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OD - 1)) ? '0 : p + AW'(1);
  endfunction

  // ---------------- decode (combinational on ffbdo) ----------------
  logic [SW-1:0] syn;
  logic          op;
  logic [CW-1:0] cw_fix;
  logic          dec_ce;
  logic          dec_ue;
  logic [DW-1:0] dec_data;

  always_comb begin
    syn = '0;
    for (int p = 1; p < CW; p++) begin
      if (ffbdo[p]) syn = syn ^ SW'(p);
    end
    op     = ^ffbdo;
    cw_fix = ffbdo;
    dec_ce = 1'b0;
    dec_ue = 1'b0;
    if (op) begin
      if (syn == '0) begin
        dec_ce = 1'b1;               // only the overall parity bit flipped
      end else if (int'(syn) < CW) begin
        cw_fix[syn] = ~cw_fix[syn];
        dec_ce      = 1'b1;
      end else begin
        dec_ue = 1'b1;               // syndrome points outside the codeword
      end
    end else if (syn != '0) begin
      dec_ue = 1'b1;                 // even number of flips: double error
    end
  end

  // Uncorrectable words leave cw_fix == ffbdo, so this is the raw data.
  for (genvar gi = 0; gi < DW; gi++) begin : g_extract
    assign dec_data[gi] = cw_fix[data_pos(gi)];
  end

  // ---------------- state ----------------
  logic           pop_q, pop_d;          // a popped word arrives on ffbdo this cycle
  logic [DW-1:0]  buf_data_q [OD];
  logic [DW-1:0]  buf_data_d [OD];
  logic           buf_ce_q   [OD];
  logic           buf_ce_d   [OD];
  logic           buf_ue_q   [OD];
  logic           buf_ue_d   [OD];
  logic [SW-1:0]  buf_syn_q  [OD];
  logic [SW-1:0]  buf_syn_d  [OD];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic [ECW-1:0] ce_cnt_q, ce_cnt_d;
  logic [ECW-1:0] ue_cnt_q, ue_cnt_d;

  logic           fire;
  logic           wr;
  logic [UW-1:0]  used;

  assign dout_valid = (cnt_q != '0);
  assign dout       = buf_data_q[rd_ptr_q];
  assign dout_ce    = buf_ce_q[rd_ptr_q];
  assign dout_ue    = buf_ue_q[rd_ptr_q];
  assign dout_syn   = buf_syn_q[rd_ptr_q];
  assign ce_cnt     = ce_cnt_q;
  assign ue_cnt     = ue_cnt_q;

  always_comb begin
    fire = dout_valid & dout_ready;
    wr   = pop_q;
    // Credits: in-flight word plus buffered words, minus the one leaving now.
    used    = UW'(cnt_q) + UW'(pop_q) - UW'(fire);
    ffbrreq = ~reset & ~ffbempty & (used < UW'(OD));
    pop_d   = ffbrreq;

    buf_data_d = buf_data_q;
    buf_ce_d   = buf_ce_q;
    buf_ue_d   = buf_ue_q;
    buf_syn_d  = buf_syn_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr) begin
      buf_data_d[wr_ptr_q] = dec_data;
      buf_ce_d[wr_ptr_q]   = dec_ce;
      buf_ue_d[wr_ptr_q]   = dec_ue;
      buf_syn_d[wr_ptr_q]  = syn;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + NW'(wr) - NW'(fire);

    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (err_clr) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else if (wr) begin
      if (dec_ce && (ce_cnt_q != '1)) ce_cnt_d = ce_cnt_q + ECW'(1);
      if (dec_ue && (ue_cnt_q != '1)) ue_cnt_d = ue_cnt_q + ECW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
      for (int i = 0; i < OD; i++) begin
        buf_data_q[i] <= '0;
        buf_ce_q[i]   <= 1'b0;
        buf_ue_q[i]   <= 1'b0;
        buf_syn_q[i]  <= '0;
      end
    end else begin
      pop_q      <= pop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ce_cnt_q   <= ce_cnt_d;
      ue_cnt_q   <= ue_cnt_d;
      buf_data_q <= buf_data_d;
      buf_ce_q   <= buf_ce_d;
      buf_ue_q   <= buf_ue_d;
      buf_syn_q  <= buf_syn_d;
    end
  end

  a_bufcnt_le_od: assert property (@(posedge clk) disable iff (reset) int'(cnt_q) <= OD);

endmodule
